// File: rtl/arranque_rampa_param.sv
`default_nettype none
// ============================================================================
//  Module      : arranque_rampa_param
//  Description : Soft-start ramp controller for the motor drive. Steps the
//                duty level up through N_STEPS speed levels (fast or slow
//                dwell), ramps down on stop, and drives the gate through a
//                built-in registered PWM stage.
//  Revision    : 1.0  initial release
// ============================================================================
module arranque_rampa_param #(
   parameter int N_STEPS    = 3,
   parameter int LEVEL_W    = 8,
   parameter int DWELL_FAST = 4,
   parameter int DWELL_SLOW = 8,
   parameter int DWELL_DOWN = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             Rapido,
   input  logic                             Lento,
   output logic [$clog2(N_STEPS+1)-1:0]     step,
   output logic [LEVEL_W-1:0]               level,
   output logic                             pwm_out,
   output logic                             running,
   output logic                             at_full
);

   // ---------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------
   localparam int c_STEP_W = $clog2(N_STEPS + 1);
   localparam int c_DMAX_UP = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
   localparam int c_DMAX = (c_DMAX_UP > DWELL_DOWN) ? c_DMAX_UP : DWELL_DOWN;
   localparam int c_CNT_W = (c_DMAX > 1) ? $clog2(c_DMAX) : 1;
   localparam int c_TAB_N = 2 ** c_STEP_W;

   localparam logic [c_CNT_W-1:0]  c_LD_FAST = c_CNT_W'(DWELL_FAST - 1);
   localparam logic [c_CNT_W-1:0]  c_LD_SLOW = c_CNT_W'(DWELL_SLOW - 1);
   localparam logic [c_CNT_W-1:0]  c_LD_DOWN = c_CNT_W'(DWELL_DOWN - 1);
   localparam logic [c_STEP_W-1:0] c_STEP_FULL = c_STEP_W'(N_STEPS);
   localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(N_STEPS - 1);
   localparam logic [c_STEP_W-1:0] c_STEP_ONE  = c_STEP_W'(1);
   // PWM counter wraps one short of all-ones so that a full-scale level
   // (all ones) is strictly greater than every count -> constant high.
   localparam logic [LEVEL_W-1:0]  c_PWM_TOP = LEVEL_W'((2 ** LEVEL_W) - 2);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RAMP_UP   = 2'd1,
      S_RUN       = 2'd2,
      S_RAMP_DOWN = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Registers and combinational helpers
   // ---------------------------------------------------------------------
   state_t                state_q;
   logic [c_STEP_W-1:0]   step_q;
   logic [c_CNT_W-1:0]    cnt_q;
   logic [LEVEL_W-1:0]    pwm_cnt_q;
   logic [LEVEL_W-1:0]    pwm_cnt_d;
   logic                  pwm_q;

   logic                  w_req;
   logic [c_CNT_W-1:0]    w_ld_up;
   logic                  w_cnt_zero;
   logic [LEVEL_W-1:0]    w_lvl_tab [0:c_TAB_N-1];

   // Run request and the ramp-up dwell it selects; Rapido wins over Lento.
   always_comb begin
      w_req      = Rapido | Lento;
      w_ld_up    = Rapido ? c_LD_FAST : c_LD_SLOW;
      w_cnt_zero = (cnt_q == '0);
   end

   // ---------------------------------------------------------------------
   // Level table: floor(k * (2^LEVEL_W - 1) / N_STEPS), fixed at elaboration.
   // Entries past N_STEPS are unreachable and tie to zero.
   // ---------------------------------------------------------------------
   for (genvar k = 0; k < c_TAB_N; k++) begin : g_lvl
      if ((k >= 1) && (k <= N_STEPS)) begin : g_on
         assign w_lvl_tab[k] = LEVEL_W'((k * ((2 ** LEVEL_W) - 1)) / N_STEPS);
      end else begin : g_off
         assign w_lvl_tab[k] = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Ramp sequencer: state, current step and dwell counter together.
   // Every step change or state entry reloads the counter with D-1.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_req) begin
                  state_q <= S_RAMP_UP;
                  step_q  <= c_STEP_ONE;
                  cnt_q   <= w_ld_up;
               end
            end

            S_RAMP_UP: begin
               if (!w_req) begin
                  // Reverse without moving the step; dwell restarts.
                  state_q <= S_RAMP_DOWN;
                  cnt_q   <= c_LD_DOWN;
               end else if (w_cnt_zero) begin
                  // Mode is re-sampled only here, so a Rapido/Lento change
                  // never shortens the dwell already in progress.
                  step_q <= step_q + c_STEP_ONE;
                  cnt_q  <= w_ld_up;
                  if (step_q == c_STEP_LAST) begin
                     state_q <= S_RUN;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_RUN: begin
               if (!w_req) begin
                  // Leaving full speed drops one step immediately.
                  state_q <= S_RAMP_DOWN;
                  step_q  <= c_STEP_LAST;
                  cnt_q   <= c_LD_DOWN;
               end
            end

            S_RAMP_DOWN: begin
               if (w_req) begin
                  state_q <= S_RAMP_UP;
                  cnt_q   <= w_ld_up;
               end else if (w_cnt_zero) begin
                  step_q <= step_q - c_STEP_ONE;
                  cnt_q  <= c_LD_DOWN;
                  if (step_q == c_STEP_ONE) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               step_q  <= '0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Free-running PWM counter next value, 0 .. 2^LEVEL_W-2.
   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == c_PWM_TOP) ? '0 : (pwm_cnt_q + 1'b1);
   end

   // PWM stage: counter is never resynchronised to step changes; the gate
   // output is registered so it lags the level by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= (pwm_cnt_q < level);
      end
   end

   // Status and duty decode from registered state/step (no extra latency).
   always_comb begin
      step    = step_q;
      level   = w_lvl_tab[step_q];
      running = (step_q != '0);
      at_full = (state_q == S_RUN);
      pwm_out = pwm_q;
   end

endmodule
`default_nettype wire
